// File: rtl/imm_encoder.sv
// Immediate packer: turns a 32-bit value plus CUOp into the 20-bit imm field the
// sign extender expands back, flagging unrepresentable values; optional LUI+ADDI split.
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_cuop,
  input  logic [31:0]      in_imm,
  input  logic             in_split,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_cuop,
  output logic [19:0]      out_field,
  output logic             out_err,
  output logic             out_last,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [5:0] CU_LUI   = 6'd0;
  localparam logic [5:0] CU_AUIPC = 6'd1;
  localparam logic [5:0] CU_JAL   = 6'd2;
  localparam logic [5:0] CU_ADDI  = 6'd18;
  localparam logic [5:0] CU_ERROR = 6'd38;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FIRST, S_SECOND} state_t;

  state_t           state_q;
  logic             out_valid_q;
  logic [5:0]       out_cuop_q;
  logic [19:0]      out_field_q;
  logic             out_err_q;
  logic             out_last_q;
  logic [11:0]      lo_q;
  logic [CNT_W-1:0] err_count_q;

  logic        fit12_s;
  logic        fit20_s;
  logic        lo_zero_s;
  logic        split_s;
  logic        legal_s;
  logic        two_beat_d;
  logic [5:0]  beat_cuop_d;
  logic [19:0] beat_field_d;
  logic        accept_s;
  logic        fire_out_s;

  // Packs the incoming request into its first (or only) output beat.
  always_comb begin
    fit12_s      = (in_imm[31:11] == {21{in_imm[31]}});
    fit20_s      = (in_imm[31:19] == {13{in_imm[31]}});
    lo_zero_s    = (in_imm[11:0] == 12'h000);
    split_s      = in_split && (in_cuop == CU_ADDI) && !fit12_s;
    two_beat_d   = split_s && !lo_zero_s;
    beat_cuop_d  = in_cuop;
    beat_field_d = 20'h00000;
    legal_s      = 1'b0;
    if (split_s) begin
      // LUI half is pre-rounded so the sign-extended ADDI low half lands exactly.
      beat_cuop_d  = CU_LUI;
      legal_s      = 1'b1;
      beat_field_d = in_imm[31:12] + {19'h00000, in_imm[11] & !lo_zero_s};
    end else begin
      case (in_cuop)
        CU_LUI, CU_AUIPC: begin
          legal_s      = lo_zero_s;
          beat_field_d = in_imm[31:12];
        end
        CU_JAL: begin
          legal_s      = fit20_s;
          beat_field_d = {in_imm[19], in_imm[7:0], in_imm[8], in_imm[18:9]};
        end
        6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9: begin
          legal_s      = fit12_s;
          beat_field_d = {8'h00, in_imm[11], in_imm[0], in_imm[10:5], in_imm[4:1]};
        end
        CU_ERROR: begin
          legal_s      = 1'b0;
          beat_field_d = 20'h00000;
        end
        default: begin
          legal_s      = fit12_s;
          beat_field_d = {8'h00, in_imm[11:0]};
        end
      endcase
      if (!legal_s) begin
        beat_field_d = 20'h00000;
      end else begin
        beat_field_d = beat_field_d;
      end
    end
  end

  assign in_ready   = (state_q == S_EMPTY) ||
                      (((state_q == S_ONE) || (state_q == S_SECOND)) && out_ready);
  assign accept_s   = in_valid && in_ready;
  assign fire_out_s = out_valid_q && out_ready;

  // Beat sequencing, output register and saturating error counter.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      out_cuop_q  <= 6'd0;
      out_field_q <= 20'h00000;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      lo_q        <= 12'h000;
      err_count_q <= {CNT_W{1'b0}};
    end else begin
      if (fire_out_s && out_err_q && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_q <= err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept_s) begin
        state_q     <= two_beat_d ? S_FIRST : S_ONE;
        out_valid_q <= 1'b1;
        out_cuop_q  <= beat_cuop_d;
        out_field_q <= beat_field_d;
        out_err_q   <= !legal_s;
        out_last_q  <= !two_beat_d;
        lo_q        <= in_imm[11:0];
      end else if (fire_out_s) begin
        if (state_q == S_FIRST) begin
          state_q     <= S_SECOND;
          out_cuop_q  <= CU_ADDI;
          out_field_q <= {8'h00, lo_q};
          out_err_q   <= 1'b0;
          out_last_q  <= 1'b1;
        end else begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_cuop  = out_cuop_q;
  assign out_field = out_field_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: value-level reference model plus directed vectors.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_cuop = 6'd0;
  logic [31:0] in_imm = 32'd0;
  logic        in_split = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_err, out_last;
  logic [5:0]  out_cuop;
  logic [19:0] out_field;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, out_err2, out_last2;
  logic [5:0]  out_cuop2;
  logic [19:0] out_field2;
  logic [1:0]  err_count2;

  typedef struct packed {
    logic [5:0]  cuop;
    logic [19:0] field;
    logic        err;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    exp_errs = 0;
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(8)) dut (
    .clk(clk), .nRst(nRst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cuop(in_cuop), .in_imm(in_imm), .in_split(in_split),
    .out_valid(out_valid), .out_ready(out_ready), .out_cuop(out_cuop),
    .out_field(out_field), .out_err(out_err), .out_last(out_last),
    .err_count(err_count)
  );

  imm_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .nRst(nRst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_cuop(in_cuop), .in_imm(in_imm), .in_split(in_split),
    .out_valid(out_valid2), .out_ready(out_ready), .out_cuop(out_cuop2),
    .out_field(out_field2), .out_err(out_err2), .out_last(out_last2),
    .err_count(err_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int m);
    return (n > m) ? m : n;
  endfunction

  // Reference: decide representability from signed ranges, then build the beats.
  function automatic void model(input logic [5:0] c, input logic [31:0] v, input logic sp);
    int          s;
    logic        fit12;
    logic        ok;
    logic [31:0] t;
    beat_t       b;
    s     = $signed(v);
    fit12 = (s >= -2048) && (s < 2048);
    if (sp && (c == 6'd18) && !fit12) begin
      if ((v % 32'd4096) == 32'd0) begin
        t = v >> 12;
        b.cuop = 6'd0; b.field = t[19:0]; b.err = 1'b0; b.last = 1'b1;
        exp_q.push_back(b);
      end else begin
        t = (v + 32'h800) >> 12;
        b.cuop = 6'd0; b.field = t[19:0]; b.err = 1'b0; b.last = 1'b0;
        exp_q.push_back(b);
        b.cuop = 6'd18; b.field = {8'h00, v[11:0]}; b.err = 1'b0; b.last = 1'b1;
        exp_q.push_back(b);
      end
    end else begin
      b.cuop = c; b.last = 1'b1;
      case (c)
        6'd0, 6'd1: begin
          ok = ((v % 32'd4096) == 32'd0);
          t = v >> 12;
          b.field = t[19:0];
        end
        6'd2: begin
          ok = (s >= -524288) && (s < 524288);
          b.field = {v[19], v[7:0], v[8], v[18:9]};
        end
        6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9: begin
          ok = fit12;
          b.field = {8'h00, v[11], v[0], v[10:5], v[4:1]};
        end
        6'd38: begin
          ok = 1'b0;
          b.field = 20'h00000;
        end
        default: begin
          ok = fit12;
          b.field = {8'h00, v[11:0]};
        end
      endcase
      b.err = !ok;
      if (!ok) b.field = 20'h00000;
      exp_q.push_back(b);
    end
  endfunction

  // Scoreboard upkeep on each handshake.
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      exp_q.delete();
      exp_errs <= 0;
    end else begin
      if (out_valid && out_ready && (exp_q.size() > 0)) begin
        if (exp_q[0].err) exp_errs <= exp_errs + 1;
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) model(in_cuop, in_imm, in_split);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (nRst) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("out_valid_w2", 32'(out_valid2), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready),
            32'((exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready)));
      check("in_ready_w2", 32'(in_ready2),
            32'((exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready)));
      if (exp_q.size() != 0) begin
        check("beat", 32'({out_cuop, out_field, out_err, out_last}), 32'(exp_q[0]));
        check("beat_w2", 32'({out_cuop2, out_field2, out_err2, out_last2}), 32'(exp_q[0]));
      end
      check("err_count", 32'(err_count), 32'(sat(exp_errs, 255)));
      check("err_count_w2", 32'(err_count2), 32'(sat(exp_errs, 3)));
    end
  end

  task automatic send(input logic [5:0] c, input logic [31:0] v, input logic sp);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_cuop = c; in_imm = v; in_split = sp;
    @(negedge clk);
    while (!in_ready && (n < 20)) begin
      n++;
      @(negedge clk);
    end
    check("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_cuop = 6'd38; in_imm = 32'hDEAD_BEEF; in_split = 1'b1;
  endtask

  task automatic expect_beat(input string nm, input logic [5:0] c, input logic [19:0] f,
                             input logic e, input logic l);
    @(negedge clk);
    check(nm, 32'({out_valid, out_cuop, out_field, out_err, out_last}), 32'({1'b1, c, f, e, l}));
  endtask

  initial begin
    #12;
    check("rst_outputs", 32'({out_valid, out_cuop, out_field, out_err, out_last}), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk); nRst = 1'b1;

    send(6'd2, 32'h0000_0100, 1'b0);
    expect_beat("jal_0x100", 6'd2, 20'h00400, 1'b0, 1'b1);

    send(6'd4, 32'hFFFF_F801, 1'b0);
    expect_beat("beq_neg", 6'd4, 20'h00C00, 1'b0, 1'b1);
    send(6'd4, 32'h0000_0800, 1'b0);
    expect_beat("beq_illegal", 6'd4, 20'h00000, 1'b1, 1'b1);
    @(negedge clk);
    check("err_count_1", 32'(err_count), 32'd1);

    send(6'd18, 32'h1234_5FFF, 1'b1);
    expect_beat("split_lui", 6'd0, 20'h12346, 1'b0, 1'b0);
    expect_beat("split_addi", 6'd18, 20'h00FFF, 1'b0, 1'b1);
    send(6'd18, 32'h00AB_C000, 1'b1);
    expect_beat("split_lui_only", 6'd0, 20'h00ABC, 1'b0, 1'b1);
    send(6'd18, 32'hFFFF_F800, 1'b1);
    expect_beat("split_addi_only", 6'd18, 20'h00800, 1'b0, 1'b1);

    send(6'd29, 32'hFFFF_FFFF, 1'b0);
    expect_beat("sub_m1", 6'd29, 20'h00FFF, 1'b0, 1'b1);
    send(6'd1, 32'hABCD_E000, 1'b0);
    expect_beat("auipc", 6'd1, 20'hABCDE, 1'b0, 1'b1);
    send(6'd6, 32'h0000_07FE, 1'b0);
    expect_beat("blt_max", 6'd6, 20'h003FF, 1'b0, 1'b1);
    send(6'd3, 32'h0000_07FF, 1'b0);
    expect_beat("jalr_max", 6'd3, 20'h007FF, 1'b0, 1'b1);

    @(posedge clk); #1 out_ready = 1'b0;
    send(6'd18, 32'h1234_5FFF, 1'b1);
    expect_beat("bp_first", 6'd0, 20'h12346, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", 32'({out_valid, out_cuop, out_field, out_last}), 32'({1'b1, 6'd0, 20'h12346, 1'b0}));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_first_still", 32'(out_field), 32'h12346);
    expect_beat("bp_second", 6'd18, 20'h00FFF, 1'b0, 1'b1);
    check("bp_in_ready_second", 32'(in_ready), 32'd1);

    send(6'd0, 32'h0000_1001, 1'b0);
    expect_beat("lui_illegal", 6'd0, 20'h00000, 1'b1, 1'b1);
    send(6'd38, 32'h0000_0000, 1'b0);
    expect_beat("error_cuop", 6'd38, 20'h00000, 1'b1, 1'b1);
    @(negedge clk);
    check("err_count_3", 32'(err_count), 32'd3);
    check("err_count_w2_3", 32'(err_count2), 32'd3);
    send(6'd2, 32'h0008_0000, 1'b0);
    expect_beat("jal_illegal", 6'd2, 20'h00000, 1'b1, 1'b1);
    send(6'd50, 32'h0000_1000, 1'b0);
    expect_beat("undef_illegal", 6'd50, 20'h00000, 1'b1, 1'b1);
    send(6'd29, 32'h1234_5FFF, 1'b1);
    expect_beat("split_ignored", 6'd29, 20'h00000, 1'b1, 1'b1);
    @(negedge clk);
    check("err_count_6", 32'(err_count), 32'd6);
    check("err_count_w2_sat", 32'(err_count2), 32'd3);

    @(posedge clk); #1 out_ready = 1'b0;
    send(6'd18, 32'h1234_5FFF, 1'b1);
    expect_beat("rst_first", 6'd0, 20'h12346, 1'b0, 1'b0);
    #2 nRst = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_count", 32'(err_count), 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); nRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_ready", 32'(in_ready), 32'd1);
    end
    send(6'd2, 32'h0000_0100, 1'b0);
    expect_beat("post_rst_jal", 6'd2, 20'h00400, 1'b0, 1'b1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
